hazard_ctrl: RTL

Pipeline controller for the register-read stage of the RV32I core. Tracks destination registers of in-flight instructions (EX, MEM, WB) in a shift scoreboard and detects RAW hazards against the read-stage instruction. Drives stall/bubble/flush for fetch and read, forwarding selects for operands A/B, and the register-file write enable/address that replace the hard-wired write enable.

---
 rtl/hazard_ctrl_pkg.sv | 60 ++++++
 rtl/hazard_scoreboard.sv | 71 +++++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the register-read hazard controller: opcodes,
// forwarding-select encodings, FSM states and the opcode decode helper.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } decode_t;

    function automatic decode_t decode_op(input logic [6:0] opcode);
        decode_t d;
        d = '0;
        case (opcode)
            OP:          begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
            OP_IMM:      begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
            LOAD:        begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_load = 1'b1; end
            JALR:        begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
            BRANCH:      begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            STORE:       begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            LUI, AUIPC,
            JAL:         d.writes_rd = 1'b1;
            default:     d = '0;
        endcase
        return d;
    endfunction

    // Scoreboard index 0/1/2 corresponds to the EX/MEM/WB bypass paths.
    function automatic fwd_sel_e stage_fwd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FWD_EX;
            2'd1:    return FWD_MEM;
            default: return FWD_WB;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight destination registers (index 0 = EX, last = WB)
// with youngest-match lookup for the two read-stage source registers.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic              push_load,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    output logic              hit_a,
    output logic [IDX_W-1:0]  idx_a,
    output logic              load_a,
    output logic              hit_b,
    output logic [IDX_W-1:0]  idx_b,
    output logic              load_b,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd
);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  is_load;
    logic [REG_AW-1:0] rd [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            is_load <= '0;
            for (int i = 0; i < DEPTH; i++) rd[i] <= '0;
        end else begin
            valid[0]   <= push;
            rd[0]      <= push ? push_rd : '0;
            is_load[0] <= push & push_load;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i]   <= valid[i-1];
                rd[i]      <= rd[i-1];
                is_load[i] <= is_load[i-1];
            end
        end
    end

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit_a  = 1'b0;
        idx_a  = '0;
        load_a = 1'b0;
        hit_b  = 1'b0;
        idx_b  = '0;
        load_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (src_a != '0) && (rd[i] == src_a)) begin
                hit_a  = 1'b1;
                idx_a  = IDX_W'(i);
                load_a = is_load[i];
            end
            if (valid[i] && (src_b != '0) && (rd[i] == src_b)) begin
                hit_b  = 1'b1;
                idx_b  = IDX_W'(i);
                load_b = is_load[i];
            end
        end
    end

    assign wb_valid = valid[DEPTH-1];
    assign wb_rd    = rd[DEPTH-1];

endmodule

// File: rtl/hazard_ctrl.sv
// Register-read stage hazard controller: decode, RUN/FLUSH FSM, stall/bubble/
// flush and operand forwarding. FORWARDING_EN enables the bypass paths.
//
//   state | meaning
//   RUN   | normal issue; detects load-use / RAW hazards and taken branches
//   FLUSH | wrong-path instruction arriving in read stage is bubbled
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       IR,
    input  logic              IR_valid,
    input  logic              branch_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              wb_en,
    output logic [REG_AW-1:0] WB_address
);

`ifdef FORWARDING_EN
    // Bypass paths exist only for EX/MEM/WB, so the depth is pinned to 3.
    localparam int SB_DEPTH = (NUM_STAGES == 3) ? NUM_STAGES : 3;
`else
    localparam int SB_DEPTH = NUM_STAGES;
`endif
    localparam int IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    decode_t           dec;
    state_e            state, state_next;
    logic [REG_AW-1:0] src_a, src_b, dst;
    logic              hit_a, hit_b, load_a, load_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              hazard, issue, push;
    fwd_sel_e          fa, fb;
    logic              unused_ir;

    assign dec   = decode_op(IR[6:0]);
    assign src_a = (IR_valid && dec.uses_rs1) ? REG_AW'(IR[19:15]) : '0;
    assign src_b = (IR_valid && dec.uses_rs2) ? REG_AW'(IR[24:20]) : '0;
    assign dst   = REG_AW'(IR[11:7]);
    assign unused_ir = ^{IR[31:25], IR[14:12]};

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .DEPTH  (SB_DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (dst),
        .push_load (dec.is_load),
        .src_a     (src_a),
        .src_b     (src_b),
        .hit_a     (hit_a),
        .idx_a     (idx_a),
        .load_a    (load_a),
        .hit_b     (hit_b),
        .idx_b     (idx_b),
        .load_b    (load_b),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd)
    );

`ifdef FORWARDING_EN
    // Only a load still in EX cannot be bypassed.
    assign hazard = (hit_a && (idx_a == '0) && load_a) ||
                    (hit_b && (idx_b == '0) && load_b);
`else
    logic unused_fwd;
    assign unused_fwd = ^{idx_a, idx_b, load_a, load_b};
    assign hazard     = hit_a || hit_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        issue      = 1'b0;
        if (rst) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        flush      = 1'b1;
                        bubble     = IR_valid;
                        state_next = FLUSH;
                    end else if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end else begin
                        issue = IR_valid;
                    end
                end
                FLUSH: begin
                    bubble     = IR_valid;
                    state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign push = issue && dec.writes_rd && (dst != '0);

    always_comb begin
        fa = FWD_RF;
        fb = FWD_RF;
`ifdef FORWARDING_EN
        if (!rst && (state == RUN) && !branch_taken && !hazard) begin
            if (hit_a) fa = stage_fwd(2'(idx_a));
            if (hit_b) fb = stage_fwd(2'(idx_b));
        end
`endif
    end

    assign fwd_a_sel  = fa;
    assign fwd_b_sel  = fb;
    assign wb_en      = !rst && wb_valid;
    assign WB_address = (rst || !wb_valid) ? '0 : wb_rd;

endmodule
